video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 170 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel divider, h/v counters, registered syncs/DE,
// multiplier-free framebuffer addressing and a frame-boundary base swap.
module video_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIX_DIV  = 2,
  parameter int   STRIDE   = 640,
  parameter int   CW       = 12,
  parameter int   AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] fb_base,
  input  logic          fb_base_we,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [AW-1:0] pix_addr,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          line_start,
  output logic          frame_start,
  output logic          swap_done,
  output logic          vblank
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [AW-1:0] STEP   = AW'(STRIDE);
  localparam logic [3:0]    DIV_LAST = 4'(PIX_DIV - 1);

  logic [3:0]    div_q, div_d;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [AW-1:0] row_q, row_d, addr_q, addr_d;
  logic [AW-1:0] cur_base_q, cur_base_d, pend_base_q, pend_base_d;
  logic          pend_q, pend_d;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic          line_q, line_d, frame_q, frame_d, swap_q, swap_d;
  logic          pe, h_wrap, v_wrap, active;

  always_comb begin
    pe     = en && (div_q == '0);
    h_wrap = (hcnt_q == H_LAST);
    v_wrap = (vcnt_q == V_LAST);
    active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);

    div_d       = div_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    row_d       = row_q;
    addr_d      = addr_q;
    cur_base_d  = cur_base_q;
    pend_base_d = pend_base_q;
    pend_d      = pend_q;
    de_d        = de_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    line_d      = 1'b0;
    frame_d     = 1'b0;
    swap_d      = 1'b0;

    if (fb_base_we) begin
      pend_base_d = fb_base;
      pend_d      = 1'b1;
    end

    if (!en) begin
      div_d  = '0;
      hcnt_d = '0;
      vcnt_d = '0;
      row_d  = '0;
      de_d   = 1'b0;
      hs_d   = ~HS_POL;
      vs_d   = ~VS_POL;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 4'd1;
      if (pe) begin
        de_d = active;
        hs_d = (hcnt_q >= H_SS && hcnt_q < H_SE) ? HS_POL : ~HS_POL;
        vs_d = (vcnt_q >= V_SS && vcnt_q < V_SE) ? VS_POL : ~VS_POL;
        // row_q tracks vcnt*STRIDE so the address needs only adders
        if (active) addr_d = cur_base_q + row_q + AW'(hcnt_q);
        if (h_wrap) begin
          hcnt_d = '0;
          line_d = 1'b1;
          if (v_wrap) begin
            vcnt_d  = '0;
            row_d   = '0;
            frame_d = 1'b1;
            if (pend_q) begin
              cur_base_d = pend_base_q;
              swap_d     = 1'b1;
              // a write landing on the swap edge stays pending for next frame
              if (!fb_base_we) pend_d = 1'b0;
            end
          end else begin
            vcnt_d = vcnt_q + CW'(1);
            row_d  = row_q + STEP;
          end
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      cur_base_q  <= '0;
      pend_base_q <= '0;
      pend_q      <= 1'b0;
      de_q        <= 1'b0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      swap_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      cur_base_q  <= cur_base_d;
      pend_base_q <= pend_base_d;
      pend_q      <= pend_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      swap_q      <= swap_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign pix_addr    = addr_q;
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign swap_done   = swap_q;
  assign vblank      = (vcnt_q >= V_ACT);

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: small 8x6 raster at PIX_DIV=1 and PIX_DIV=3.
module tb_video_timing_gen;
  localparam int AW = 32;
  localparam int CW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, fb_base_we;
  logic [AW-1:0] fb_base;
  logic          hs, vs, de, line_start, frame_start, swap_done, vblank;
  logic [AW-1:0] pix_addr;
  logic [CW-1:0] hcnt, vcnt;

  logic          rst3, en3, fb_base_we3;
  logic [AW-1:0] fb_base3;
  logic          hs3, vs3, de3, line_start3, frame_start3, swap_done3, vblank3;
  logic [AW-1:0] pix_addr3;
  logic [CW-1:0] hcnt3, vcnt3;

  int checks   = 0;
  int failures = 0;

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(1), .STRIDE(8), .CW(CW), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .fb_base(fb_base), .fb_base_we(fb_base_we),
    .hs(hs), .vs(vs), .de(de), .pix_addr(pix_addr), .hcnt(hcnt), .vcnt(vcnt),
    .line_start(line_start), .frame_start(frame_start), .swap_done(swap_done),
    .vblank(vblank)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(3), .STRIDE(8), .CW(CW), .AW(AW)
  ) dut3 (
    .clk(clk), .rst(rst3), .en(en3), .fb_base(fb_base3), .fb_base_we(fb_base_we3),
    .hs(hs3), .vs(vs3), .de(de3), .pix_addr(pix_addr3), .hcnt(hcnt3), .vcnt(vcnt3),
    .line_start(line_start3), .frame_start(frame_start3), .swap_done(swap_done3),
    .vblank(vblank3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Framebuffer base in effect for frame f of the main sequence
  function automatic int base_of(input int f);
    case (f)
      0:       return 0;
      1:       return 'h100;
      2:       return 'h180;
      default: return 'h200;
    endcase
  endfunction

  initial begin
    int p, x, l, f, q;

    rst = 1'b0; en = 1'b1; fb_base = '0; fb_base_we = 1'b0;
    rst3 = 1'b0; en3 = 1'b1; fb_base3 = '0; fb_base_we3 = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_hcnt", hcnt, 0);
    check("rst_vcnt", vcnt, 0);
    check("rst_de", de, 0);
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_addr", pix_addr, 0);
    check("rst_vblank", vblank, 0);
    check("rst_pulses", {line_start, frame_start, swap_done}, 0);
    check("rst3_syncs", {hs3, vs3, de3}, 3'b110);
    check("rst3_misc", {line_start3, frame_start3, swap_done3, vblank3}, 0);
    check("rst3_addr", pix_addr3, 0);

    // Frames 0..4 from reset release; base writes at n=10, 60 and on the swap edge n=96
    rst = 1'b1;
    for (int n = 1; n <= 209; n++) begin
      @(negedge clk);
      p = n - 1; x = p % 8; l = (p / 8) % 6; f = p / 48;
      check("hcnt", hcnt, n % 8);
      check("vcnt", vcnt, (n / 8) % 6);
      check("de", de, (x < 4 && l < 3) ? 1 : 0);
      check("hs", hs, (x == 5 || x == 6) ? 0 : 1);
      check("vs", vs, (l == 4) ? 0 : 1);
      check("vblank", vblank, (((n / 8) % 6) >= 3) ? 1 : 0);
      check("line_start", line_start, (n % 8 == 0) ? 1 : 0);
      check("frame_start", frame_start, (n % 48 == 0) ? 1 : 0);
      check("swap_done", swap_done, (n == 48 || n == 96 || n == 144) ? 1 : 0);
      if (x < 4 && l < 3) check("pix_addr", pix_addr, base_of(f) + l * 8 + x);
      fb_base_we = 1'b0;
      if (n == 10) begin fb_base_we = 1'b1; fb_base = 'h100; end
      if (n == 60) begin fb_base_we = 1'b1; fb_base = 'h180; end
      if (n == 95) begin fb_base_we = 1'b1; fb_base = 'h200; end
    end

    // en dropped at vcnt=2, hcnt=1
    en = 1'b0;
    @(negedge clk);
    check("dis_hcnt", hcnt, 0);
    check("dis_vcnt", vcnt, 0);
    check("dis_de", de, 0);
    check("dis_hs", hs, 1);
    check("dis_vs", vs, 1);
    check("dis_pulses", {line_start, frame_start, swap_done}, 0);
    fb_base_we = 1'b1; fb_base = 'h400;
    @(negedge clk);
    fb_base_we = 1'b0;
    check("dis_hold_hcnt", hcnt, 0);

    en = 1'b1;
    for (int k = 1; k <= 51; k++) begin
      @(negedge clk);
      check("re_hcnt", hcnt, k % 8);
      check("re_swap", swap_done, (k == 48) ? 1 : 0);
      if (k == 1) begin
        check("re_de", de, 1);
        check("re_addr0", pix_addr, 'h200);
      end
      if (k == 48) check("re_frame", frame_start, 1);
      if (k == 49) check("re_addr_new", pix_addr, 'h400);
      if (k == 51) check("re_addr_mid", pix_addr, 'h402);
    end

    // Asynchronous reset mid-line: no clock edge before the sample
    #1 rst = 1'b0;
    #1;
    check("arst_hcnt", hcnt, 0);
    check("arst_vcnt", vcnt, 0);
    check("arst_de", de, 0);
    check("arst_syncs", {hs, vs}, 2'b11);
    check("arst_addr", pix_addr, 0);
    check("arst_misc", {line_start, frame_start, swap_done, vblank}, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("arst_restart_hcnt", hcnt, 1);
    check("arst_restart_de", de, 1);
    check("arst_restart_addr", pix_addr, 0);

    // PIX_DIV=3 instance: pe on clks 1,4,7,...; line is 24 clks
    rst3 = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      q = (k + 2) / 3;
      check("d3_hcnt", hcnt3, q % 8);
      check("d3_vcnt", vcnt3, (q / 8) % 6);
      check("d3_line_start", line_start3, (k == 22 || k == 46) ? 1 : 0);
      check("d3_de", de3, (((q - 1) % 8) < 4) ? 1 : 0);
    end
    en3 = 1'b0;
    @(negedge clk);
    check("d3_dis_hcnt", hcnt3, 0);
    check("d3_dis_vcnt", vcnt3, 0);
    check("d3_dis_de", de3, 0);
    en3 = 1'b1;
    @(negedge clk);
    check("d3_first_pe", hcnt3, 1);
    @(negedge clk);
    @(negedge clk);
    check("d3_hold", hcnt3, 1);
    @(negedge clk);
    check("d3_second_pe", hcnt3, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
